// File: rtl/mmss_bcd_timer_pkg.sv
// Shared definitions for the MM:SS BCD timer: FSM state codes, digit limits
// and the load-value clamp helper.
package mmss_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] MIN_TENS_MAX = 4'd5;
  localparam logic [3:0] UNIT_MAX     = 4'd9;

  // Digit order matches the 16-bit BCD load/display word.
  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_unit;
    logic [3:0] sec_tens;
    logic [3:0] sec_unit;
  } mmss_t;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] mx);
    return (d > mx) ? mx : d;
  endfunction

  // Out-of-range digits saturate to the digit's maximum.
  function automatic mmss_t clamp_mmss(input logic [15:0] v);
    mmss_t r;
    r.min_tens = clamp_digit(v[15:12], MIN_TENS_MAX);
    r.min_unit = clamp_digit(v[11:8],  UNIT_MAX);
    r.sec_tens = clamp_digit(v[7:4],   SEC_TENS_MAX);
    r.sec_unit = clamp_digit(v[3:0],   UNIT_MAX);
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit, 0..MAX, wrapping up or down when enabled.
// o_carry / o_borrow flag that the digit sits at its wrap point in the
// current direction; the top chains enables with them.
// Down-counting is only built when MMSS_COUNTDOWN_EN is defined.
module bcd_digit_counter
  import mmss_pkg::*;
#(
  parameter logic [3:0] MAX = UNIT_MAX
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_en,
  input  logic       i_up,
  output logic [3:0] o_q,
  output logic       o_carry,
  output logic       o_borrow
);

  logic [3:0] r_q;

`ifdef MMSS_COUNTDOWN_EN
  // Digit register: clear > load > step up/down with wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_q <= '0;
    else if (i_clr)            r_q <= '0;
    else if (i_load)           r_q <= i_load_val;
    else if (i_en && i_up)     r_q <= (r_q == MAX) ? 4'd0 : r_q + 4'd1;
    else if (i_en)             r_q <= (r_q == 4'd0) ? MAX : r_q - 4'd1;
  end

  assign o_borrow = ~i_up & (r_q == 4'd0);
`else
  // Digit register: clear > load > step up with wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_q <= '0;
    else if (i_clr)   r_q <= '0;
    else if (i_load)  r_q <= i_load_val;
    else if (i_en)    r_q <= (r_q == MAX) ? 4'd0 : r_q + 4'd1;
  end

  assign o_borrow = 1'b0;
`endif

  assign o_carry = i_up & (r_q == MAX);
  assign o_q     = r_q;

endmodule

// File: rtl/mmss_bcd_timer.sv
// MM:SS BCD timer feeding the 4-digit display decoder.
// Prescaler divides clk by TICK_DIV; each tick steps the BCD count while
// in RUN. Hitting the terminal value on a tick freezes the count in DONE.
// Optional down-counting is enabled by defining MMSS_COUNTDOWN_EN.
module mmss_bcd_timer
  import mmss_pkg::*;
#(
  parameter int TICK_DIV = 50000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        dir_down,
  output logic [3:0]  second_unit,
  output logic [3:0]  second_tens,
  output logic [3:0]  minute_unit,
  output logic [3:0]  minute_tens,
  output logic        running,
  output logic        done,
  output logic        done_pulse
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  state_t          r_state;
  state_t          w_nxt;
  logic [PW-1:0]   r_presc;
  logic            r_running;
  logic            r_done;
  logic            r_done_pulse;

  logic            w_run_cyc;
  logic            w_tick;
  logic            w_up;
  logic            w_term;
  logic            w_step;
  mmss_t           w_ld;
  logic [3:0][3:0] w_ld_dig;
  logic [3:0][3:0] w_dig;
  logic [3:0]      w_en;
  logic [3:0]      w_cy;
  logic [3:0]      w_bw;

`ifdef MMSS_COUNTDOWN_EN
  assign w_up = ~dir_down;
`else
  // Up-only build: direction is fixed, dir_down has no effect.
  assign w_up = 1'b1 | dir_down;
`endif

  // A RUN cycle advances the prescaler unless a control request overrides it.
  assign w_run_cyc = (r_state == S_RUN) & ~clear & ~load & ~stop;
  assign w_tick    = w_run_cyc & (r_presc == PRE_LAST);

  // Terminal value: every digit at its wrap point in the current direction.
  assign w_term = &(w_cy | w_bw);
  assign w_step = w_tick & ~w_term;

  assign w_ld     = clamp_mmss(load_value);
  assign w_ld_dig = w_ld;

  // Digit 0 = seconds units ... digit 3 = minutes tens, rippling by carry/borrow.
  assign w_en[0] = w_step;

  for (genvar i = 0; i < 4; i++) begin : g_dig
    localparam logic [3:0] DMAX = (i == 0 || i == 2) ? UNIT_MAX :
                                  (i == 1) ? SEC_TENS_MAX : MIN_TENS_MAX;
    bcd_digit_counter #(.MAX(DMAX)) u_dig (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clr      (clear),
      .i_load     (load),
      .i_load_val (w_ld_dig[i]),
      .i_en       (w_en[i]),
      .i_up       (w_up),
      .o_q        (w_dig[i]),
      .o_carry    (w_cy[i]),
      .o_borrow   (w_bw[i])
    );
    if (i < 3) begin : g_chain
      assign w_en[i+1] = w_en[i] & (w_cy[i] | w_bw[i]);
    end
  end

  // Next-state: clear/load force IDLE, then stop beats start.
  always_comb begin
    w_nxt = r_state;
    if (clear || load) begin
      w_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start && !stop) w_nxt = S_RUN;
        S_RUN:   if (stop) w_nxt = S_IDLE;
                 else if (w_tick && w_term) w_nxt = S_DONE;
        S_DONE:  w_nxt = S_DONE;
        default: w_nxt = S_IDLE;
      endcase
    end
  end

  // State and registered status flags; done_pulse marks entry into DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_running    <= 1'b0;
      r_done       <= 1'b0;
      r_done_pulse <= 1'b0;
    end else begin
      r_state      <= w_nxt;
      r_running    <= (w_nxt == S_RUN);
      r_done       <= (w_nxt == S_DONE);
      r_done_pulse <= (w_nxt == S_DONE) && (r_state != S_DONE);
    end
  end

  // Prescaler: zeroed by clear/load, held while paused so resume keeps the partial tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_presc <= '0;
    else if (clear || load)  r_presc <= '0;
    else if (w_tick)         r_presc <= '0;
    else if (w_run_cyc)      r_presc <= r_presc + 1'b1;
  end

  assign second_unit = w_dig[0];
  assign second_tens = w_dig[1];
  assign minute_unit = w_dig[2];
  assign minute_tens = w_dig[3];
  assign running     = r_running;
  assign done        = r_done;
  assign done_pulse  = r_done_pulse;

endmodule
